// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: widths, reset vector, opcode encodings, field positions.
// Pure declarations, no logic; imported by the fetch stage and decode.
// Field positions follow the base 32-bit instruction encoding.
package riscv_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Major opcode values for the base formats
  typedef enum logic [6:0] {
    OP_R = 7'b0110011,
    OP_I = 7'b0010011,
    OP_S = 7'b0100011,
    OP_B = 7'b1100011,
    OP_U = 7'b0110111,
    OP_J = 7'b1101111
  } opcode_t;

  // Instruction field bit positions
  localparam int OPCODE_LSB = 0;
  localparam int OPCODE_MSB = 6;
  localparam int RD_LSB     = 7;
  localparam int RD_MSB     = 11;
  localparam int FUNCT3_LSB = 12;
  localparam int FUNCT3_MSB = 14;
  localparam int RS1_LSB    = 15;
  localparam int RS1_MSB    = 19;
  localparam int RS2_LSB    = 20;
  localparam int RS2_MSB    = 24;
  localparam int FUNCT7_LSB = 25;
  localparam int FUNCT7_MSB = 31;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: single-outstanding word fetch into an instruction register presented to decode.
// Latency: request accepted at edge N, response at N+k, dec_valid from edge N+k (>=3 cycles per instr).
// Backpressure: holds the instruction and issues no request until decode accepts or a redirect arrives.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int unsigned     XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] pc,
  output logic [6:0]      opcode,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2
);

  typedef enum logic [2:0] {BOOT, REQ, WAIT, DROP, HOLD} fetch_state_t;

  fetch_state_t    state, state_nxt;
  logic [XLEN-1:0] fetch_pc, fetch_pc_nxt;
  logic [XLEN-1:0] req_pc, req_pc_nxt;
  logic [31:0]     instr_nxt;
  logic [XLEN-1:0] pc_nxt;
  logic            dec_valid_nxt;
  logic [XLEN-1:0] target;

  // Redirect targets are forced word-aligned
  assign target        = {redirect_target[XLEN-1:2], 2'b00};
  assign imem_req_addr = fetch_pc;

  assign opcode = instr[OPCODE_MSB:OPCODE_LSB];
  assign rd     = instr[RD_MSB:RD_LSB];
  assign funct3 = instr[FUNCT3_MSB:FUNCT3_LSB];
  assign rs1    = instr[RS1_MSB:RS1_LSB];
  assign rs2    = instr[RS2_MSB:RS2_LSB];
  assign funct7 = instr[FUNCT7_MSB:FUNCT7_LSB];

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= BOOT;
      fetch_pc  <= RESET_PC;
      req_pc    <= '0;
      instr     <= '0;
      pc        <= '0;
      dec_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      fetch_pc  <= fetch_pc_nxt;
      req_pc    <= req_pc_nxt;
      instr     <= instr_nxt;
      pc        <= pc_nxt;
      dec_valid <= dec_valid_nxt;
    end
  end

  // Next-state and request output; a redirect outranks every other event
  always_comb begin
    state_nxt      = state;
    fetch_pc_nxt   = fetch_pc;
    req_pc_nxt     = req_pc;
    instr_nxt      = instr;
    pc_nxt         = pc;
    dec_valid_nxt  = dec_valid;
    imem_req_valid = 1'b0;
    case (state)
      BOOT: state_nxt = REQ;
      REQ: begin
        imem_req_valid = 1'b1;
        if (imem_req_ready && redirect_valid) begin
          // Old-address request is in flight; its response must be dropped
          fetch_pc_nxt = target;
          state_nxt    = DROP;
        end else if (imem_req_ready) begin
          req_pc_nxt   = fetch_pc;
          fetch_pc_nxt = fetch_pc + XLEN'(4);
          state_nxt    = WAIT;
        end else if (redirect_valid) begin
          fetch_pc_nxt = target;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          fetch_pc_nxt = target;
          state_nxt    = imem_resp_valid ? REQ : DROP;
        end else if (imem_resp_valid) begin
          instr_nxt     = imem_resp_data;
          pc_nxt        = req_pc;
          dec_valid_nxt = 1'b1;
          state_nxt     = HOLD;
        end
      end
      DROP: begin
        if (redirect_valid) fetch_pc_nxt = target;
        if (imem_resp_valid) state_nxt = REQ;
      end
      HOLD: begin
        if (redirect_valid) begin
          dec_valid_nxt = 1'b0;
          fetch_pc_nxt  = target;
          state_nxt     = REQ;
        end else if (dec_ready) begin
          dec_valid_nxt = 1'b0;
          state_nxt     = REQ;
        end
      end
      default: state_nxt = BOOT;
    endcase
  end

  // A response is only legal while one is outstanding
  resp_only_when_outstanding: assert property (
    @(posedge clk) disable iff (reset)
    imem_resp_valid |-> (state == WAIT || state == DROP)
  );

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;

  int total = 0;
  int bad   = 0;

  // Expected {pc, instr} of each instruction that must reach decode
  logic [63:0] sb[$];

  fetch_unit dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .instr(instr), .pc(pc), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .rd(rd), .rs1(rs1), .rs2(rs2)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for an instruction at decode and compare it with the scoreboard head
  task automatic check_dec(input string tag);
    logic [63:0] e;
    for (int i = 0; i < 20 && !dec_valid; i++) tick();
    chk({tag, "_dec_valid"}, 64'(dec_valid), 64'd1);
    if (sb.size() == 0) begin
      chk({tag, "_sb_nonempty"}, 64'(sb.size()), 64'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_pc"}, 64'(pc), 64'(e[63:32]));
      chk({tag, "_instr"}, 64'(instr), 64'(e[31:0]));
    end
  endtask

  // Respond in WAIT with a word that decode must see at address a
  task automatic respond_fwd(input logic [31:0] a, input logic [31:0] d);
    imem_resp_valid = 1'b1;
    imem_resp_data  = d;
    sb.push_back({a, d});
    tick();
    imem_resp_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] held_instr;
    reset           = 1'b1;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    redirect_valid  = 1'b0;
    redirect_target = '0;
    dec_ready       = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
    chk("rst_req_addr", 64'(imem_req_addr), 64'h0);
    chk("rst_dec_valid", 64'(dec_valid), 64'd0);
    chk("rst_instr", 64'(instr), 64'h0);
    chk("rst_pc", 64'(pc), 64'h0);
    chk("rst_opcode", 64'(opcode), 64'h0);

    // First fetch at address 0, one-cycle memory
    reset = 1'b0;
    tick();
    chk("t1_req_valid", 64'(imem_req_valid), 64'd1);
    chk("t1_req_addr", 64'(imem_req_addr), 64'h0);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    chk("t1_wait_no_req", 64'(imem_req_valid), 64'd0);
    chk("t1_wait_no_dec", 64'(dec_valid), 64'd0);
    respond_fwd(32'h0, 32'h00A0_0093);
    check_dec("t1");
    chk("t1_opcode", 64'(opcode), 64'(7'b0010011));
    chk("t1_rd", 64'(rd), 64'd1);
    chk("t1_rs1", 64'(rs1), 64'd0);
    chk("t1_funct3", 64'(funct3), 64'd0);
    chk("t1_rs2", 64'(rs2), 64'd10);
    chk("t1_funct7", 64'(funct7), 64'd0);

    // Decode stalls for 5 cycles: everything holds, no new request
    held_instr = instr;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_hold_valid", 64'(dec_valid), 64'd1);
      chk("t2_hold_instr", 64'(instr), 64'(held_instr));
      chk("t2_hold_pc", 64'(pc), 64'h0);
      chk("t2_hold_no_req", 64'(imem_req_valid), 64'd0);
    end
    dec_ready = 1'b1;
    tick();
    dec_ready = 1'b0;
    chk("t2_dec_drop", 64'(dec_valid), 64'd0);
    chk("t2_req_valid", 64'(imem_req_valid), 64'd1);
    chk("t2_req_addr", 64'(imem_req_addr), 64'h4);

    // Redirect coincident with the response in WAIT: response discarded
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hDEAD_BEEF;
    redirect_valid  = 1'b1;
    redirect_target = 32'h100;
    tick();
    imem_resp_valid = 1'b0;
    redirect_valid  = 1'b0;
    chk("t3_dec_valid", 64'(dec_valid), 64'd0);
    chk("t3_req_valid", 64'(imem_req_valid), 64'd1);
    chk("t3_req_addr", 64'(imem_req_addr), 64'h100);

    // Misaligned redirect in WAIT, late response dropped, then fetch from 0x200
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready  = 1'b0;
    redirect_valid  = 1'b1;
    redirect_target = 32'h203;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("t4_drop_no_req", 64'(imem_req_valid), 64'd0);
      chk("t4_drop_no_dec", 64'(dec_valid), 64'd0);
      tick();
    end
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hBAD0_0013;
    tick();
    imem_resp_valid = 1'b0;
    chk("t4_dec_valid", 64'(dec_valid), 64'd0);
    chk("t4_req_valid", 64'(imem_req_valid), 64'd1);
    chk("t4_req_addr", 64'(imem_req_addr), 64'h200);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    respond_fwd(32'h200, 32'h0020_81B3);
    check_dec("t4");
    chk("t4_opcode", 64'(opcode), 64'(7'b0110011));
    chk("t4_rd", 64'(rd), 64'd3);
    chk("t4_rs1", 64'(rs1), 64'd1);
    chk("t4_rs2", 64'(rs2), 64'd2);

    // Redirect together with dec_ready in HOLD: redirect target wins
    redirect_valid  = 1'b1;
    redirect_target = 32'h300;
    dec_ready       = 1'b1;
    tick();
    redirect_valid = 1'b0;
    dec_ready      = 1'b0;
    chk("t5_dec_valid", 64'(dec_valid), 64'd0);
    chk("t5_req_valid", 64'(imem_req_valid), 64'd1);
    chk("t5_req_addr", 64'(imem_req_addr), 64'h300);

    // Unaccepted request retargeted to the top word, then PC wraps to 0
    redirect_valid  = 1'b1;
    redirect_target = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    chk("t6_req_valid", 64'(imem_req_valid), 64'd1);
    chk("t6_req_addr", 64'(imem_req_addr), 64'hFFFF_FFFC);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    respond_fwd(32'hFFFF_FFFC, 32'h0000_0537);
    check_dec("t6");
    dec_ready = 1'b1;
    tick();
    dec_ready = 1'b0;
    chk("t6_wrap_req_valid", 64'(imem_req_valid), 64'd1);
    chk("t6_wrap_addr", 64'(imem_req_addr), 64'h0);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    chk("t6_wait_addr", 64'(imem_req_addr), 64'h4);

    // Reset during WAIT (after one decoded instruction) clears outputs without a clock edge
    redirect_valid  = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("t7_req_valid", 64'(imem_req_valid), 64'd0);
    chk("t7_req_addr", 64'(imem_req_addr), 64'h0);
    chk("t7_dec_valid", 64'(dec_valid), 64'd0);
    chk("t7_pc", 64'(pc), 64'h0);
    chk("t7_instr", 64'(instr), 64'h0);
    chk("t7_sb_empty", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the decode controller.
- Holds the PC, issues single-outstanding word requests to instruction memory over a valid/ready request channel plus a response-valid channel, and captures the returned word in an instruction register.
- Presents opcode/funct3/funct7/register fields and the instruction's PC to decode under a valid/ready handshake.
- Accepts branch/jump redirects from execute; stale responses are discarded.

Parameters:
XLEN  32  width of PC, addresses and instruction word
RESET_PC  32'h0000_0000  first fetch address after reset

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request this cycle
imem_req_addr  output  XLEN  word-aligned fetch address
imem_resp_valid  input  1  response word valid (one per accepted request, in order)
imem_resp_data  input  32  fetched instruction word
redirect_valid  input  1  branch/jump taken (pc_source=1 from execute)
redirect_target  input  XLEN  new PC
dec_valid  output  1  instruction available to decode
dec_ready  input  1  decode consumes instruction this cycle
instr  output  32  captured instruction word
pc  output  XLEN  address of captured instruction
opcode  output  7  instr[6:0]
funct3  output  3  instr[14:12]
funct7  output  7  instr[31:25]
rd  output  5  instr[11:7]
rs1  output  5  instr[19:15]
rs2  output  5  instr[24:20]

Behaviour:
- Interface (decided): one clock `clk`; `reset` is asynchronous and active-high.
- State register fetch_pc; registered pc, instr and dec_valid; all fields are pure slices of the registered instr.
- While reset is asserted: state=BOOT, fetch_pc=RESET_PC, instr=0, pc=0, dec_valid=0, imem_req_valid=0, imem_req_addr=RESET_PC. All fields therefore read 0.
- imem_req_valid=1 only in REQ. imem_req_addr=fetch_pc at all times.
- Transitions; redirect has priority over every other event.
  - BOOT: -> REQ unconditionally on the next edge.
  - REQ, ready & redirect: request is accepted with the old address; fetch_pc<=target; -> DROP.
  - REQ, ready only: req_pc<=fetch_pc; fetch_pc<=fetch_pc+4; -> WAIT.
  - REQ, redirect only: fetch_pc<=target; stay REQ. Changing the address of an unaccepted request is legal on this interface.
  - WAIT, resp_valid only: instr<=resp_data; pc<=req_pc; dec_valid<=1; -> HOLD.
  - WAIT, resp_valid & redirect: response discarded; fetch_pc<=target; -> REQ.
  - WAIT, redirect only: fetch_pc<=target; -> DROP.
  - DROP: on resp_valid the data is discarded and the state goes -> REQ. A redirect in DROP updates fetch_pc and stays DROP. Responses are never forwarded from DROP.
  - HOLD, redirect: dec_valid<=0; fetch_pc<=target; -> REQ. This wins over a simultaneous dec_ready.
  - HOLD, dec_ready only: dec_valid<=0; -> REQ.
  - HOLD, neither: instr, pc and dec_valid stay stable.
- Latency: request accepted at edge N, response at edge N+k (k>=1), dec_valid high from edge N+k. Best-case throughput is one instruction per 3 cycles with zero-wait memory.
- Arithmetic:
  - fetch_pc+4 is modulo 2^XLEN; 0xFFFF_FFFC wraps to 0x0000_0000.
  - redirect_target[1:0] is forced to 2'b00 on load.
- At most one request is outstanding. imem_resp_valid in REQ, BOOT or HOLD is a protocol error: ignored, with an assertion in simulation.
- Reset asserted mid-operation aborts everything immediately; an in-flight response after reset release is the memory's responsibility (memory shares reset).

Decomposition:
- Shared package riscv_pkg holds:
  - opcode enum (R/I/S/B/U/J values)
  - field bit-position constants
  - XLEN default
  - RESET_PC default
- Fetch state enum (BOOT, REQ, WAIT, DROP, HOLD) stays local to the module.
- No sub-module; a separate PC register module is not warranted.

Test Plan:
- Reset release, memory ready=1 with 1-cycle response 0x00A00093 at addr 0 -> req_addr 0, then dec_valid=1, pc=0, opcode=0010011, rd=1, rs1=0, funct3=000.
- dec_ready held 0 for 5 cycles in HOLD -> instr/pc/dec_valid stable, no new imem_req_valid; dec_ready=1 -> next request at addr 4.
- Redirect to 0x100 in the same cycle as resp_valid (WAIT) -> response dropped, dec_valid stays 0, next request addr 0x100.
- Redirect to 0x203 while in WAIT, response arrives 3 cycles later -> discarded, next request addr 0x200, then dec pc=0x200.
- Redirect and dec_ready together in HOLD -> dec_valid falls, next request addr=target.
- Redirect to 0xFFFF_FFFC, two sequential fetches -> second request addr 0x0000_0000; reset asserted during WAIT -> outputs return to reset values asynchronously.
